// File: rtl/rope_mover2d_if.sv
// Control/status bundle between the frame logic and the 2-D rope mover.
// The controller side drives frame pulses, commands and collision toggles; the mover side returns position and status.
interface rope_mover2d_if #(
   parameter int COORD_W = 11,
   parameter int SPEED_W = 16
);
   logic                      startOfFrame;
   logic                      start;
   logic                      stop;
   logic                      load;
   logic signed [COORD_W-1:0] loadX;
   logic signed [COORD_W-1:0] loadY;
   logic signed [SPEED_W-1:0] loadVX;
   logic signed [SPEED_W-1:0] loadVY;
   logic                      dirToggleX;
   logic                      dirToggleY;
   logic signed [COORD_W-1:0] topLeftX;
   logic signed [COORD_W-1:0] topLeftY;
   logic                      moving;
   logic                      bounced;

   modport master (
      output startOfFrame, start, stop, load, loadX, loadY, loadVX, loadVY, dirToggleX, dirToggleY,
      input  topLeftX, topLeftY, moving, bounced
   );

   modport slave (
      input  startOfFrame, start, stop, load, loadX, loadY, loadVX, loadVY, dirToggleX, dirToggleY,
      output topLeftX, topLeftY, moving, bounced
   );
endinterface

// File: rtl/rope_mover2d.sv
// 2-D fixed-point sprite mover: per-frame velocity integration, collision direction toggles,
// bounce or wrap at playfield bounds, and an idle/run/hold sequencer.
module rope_mover2d #(
   parameter int FRAC_BITS   = 6,
   parameter int COORD_W     = 11,
   parameter int SPEED_W     = 16,
   parameter int INIT_X      = 280,
   parameter int INIT_Y      = 100,
   parameter int INIT_VX     = 30,
   parameter int INIT_VY     = 0,
   parameter int MIN_X       = 0,
   parameter int MAX_X       = 639,
   parameter int MIN_Y       = 0,
   parameter int MAX_Y       = 479,
   parameter int WRAP_MODE   = 0,
   parameter int HOLD_FRAMES = 0
) (
   input  logic          clk,
   input  logic          resetN,
   rope_mover2d_if.slave bus
);
   localparam int PW   = COORD_W + FRAC_BITS + 2;
   localparam int HC_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

   localparam logic signed [PW-1:0] LO_X    = PW'(MIN_X * (2 ** FRAC_BITS));
   localparam logic signed [PW-1:0] HI_X    = PW'(MAX_X * (2 ** FRAC_BITS));
   localparam logic signed [PW-1:0] LO_Y    = PW'(MIN_Y * (2 ** FRAC_BITS));
   localparam logic signed [PW-1:0] HI_Y    = PW'(MAX_Y * (2 ** FRAC_BITS));
   localparam logic signed [PW-1:0] SPAN_X  = PW'((MAX_X - MIN_X + 1) * (2 ** FRAC_BITS));
   localparam logic signed [PW-1:0] SPAN_Y  = PW'((MAX_Y - MIN_Y + 1) * (2 ** FRAC_BITS));
   localparam logic signed [PW-1:0] INIT_PX = PW'(INIT_X * (2 ** FRAC_BITS));
   localparam logic signed [PW-1:0] INIT_PY = PW'(INIT_Y * (2 ** FRAC_BITS));
   localparam logic signed [SPEED_W-1:0] INIT_VX_C = SPEED_W'(INIT_VX);
   localparam logic signed [SPEED_W-1:0] INIT_VY_C = SPEED_W'(INIT_VY);
   localparam logic [HC_W-1:0] HOLD_C = HC_W'(HOLD_FRAMES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t                    state_r, state_s;
   logic [HC_W-1:0]           hold_r, hold_s;
   logic signed [PW-1:0]      pos_x_r, pos_x_s, pos_y_r, pos_y_s;
   logic signed [SPEED_W-1:0] v_x_r, v_x_s, v_y_r, v_y_s;
   logic                      lock_x_r, lock_x_s, lock_y_r, lock_y_s;
   logic                      bounced_r, bounced_s;
   logic                      tog_x_s, tog_y_s, step_s;
   logic signed [PW-1:0]      step_px_s, step_py_s;
   logic signed [SPEED_W-1:0] step_vx_s, step_vy_s;
   logic                      hit_x_s, hit_y_s;

   // The most negative velocity has no positive twin, so negation saturates.
   function automatic logic signed [SPEED_W-1:0] neg_sat(input logic signed [SPEED_W-1:0] v);
      logic signed [SPEED_W-1:0] most_neg;
      most_neg = {1'b1, {(SPEED_W-1){1'b0}}};
      if (v == most_neg) begin
         return {1'b0, {(SPEED_W-1){1'b1}}};
      end else begin
         return -v;
      end
   endfunction

   function automatic logic signed [SPEED_W-1:0] abs_sat(input logic signed [SPEED_W-1:0] v);
      if (v[SPEED_W-1]) begin
         return neg_sat(v);
      end else begin
         return v;
      end
   endfunction

   function automatic void axis_step(
      input  logic signed [PW-1:0]      pos,
      input  logic signed [SPEED_W-1:0] v,
      input  logic signed [PW-1:0]      lo,
      input  logic signed [PW-1:0]      hi,
      input  logic signed [PW-1:0]      span,
      output logic signed [PW-1:0]      pos_o,
      output logic signed [SPEED_W-1:0] v_o,
      output logic                      hit_o
   );
      logic signed [PW-1:0] n;
      n     = pos + {{(PW-SPEED_W){v[SPEED_W-1]}}, v};
      pos_o = n;
      v_o   = v;
      hit_o = 1'b0;
      if (n < lo) begin
         hit_o = 1'b1;
         if (WRAP_MODE != 0) begin
            pos_o = n + span;
         end else begin
            pos_o = lo;
            v_o   = abs_sat(v);
         end
      end else if (n > hi) begin
         hit_o = 1'b1;
         if (WRAP_MODE != 0) begin
            pos_o = n - span;
         end else begin
            pos_o = hi;
            v_o   = v[SPEED_W-1] ? v : neg_sat(v);
         end
      end else begin
         pos_o = n;
      end
   endfunction

   // Next-state, datapath and status computation.
   always_comb begin
      state_s   = state_r;
      hold_s    = hold_r;
      pos_x_s   = pos_x_r;
      pos_y_s   = pos_y_r;
      bounced_s = 1'b0;
      tog_x_s   = bus.dirToggleX & ~lock_x_r;
      tog_y_s   = bus.dirToggleY & ~lock_y_r;
      v_x_s     = tog_x_s ? neg_sat(v_x_r) : v_x_r;
      v_y_s     = tog_y_s ? neg_sat(v_y_r) : v_y_r;
      // A frame pulse re-arms the locks even when it coincides with a toggle.
      if (bus.startOfFrame) begin
         lock_x_s = 1'b0;
         lock_y_s = 1'b0;
      end else begin
         lock_x_s = lock_x_r | tog_x_s;
         lock_y_s = lock_y_r | tog_y_s;
      end
      step_s = bus.startOfFrame & (state_r == ST_RUN) & ~bus.load & ~bus.stop;
      axis_step(pos_x_r, v_x_s, LO_X, HI_X, SPAN_X, step_px_s, step_vx_s, hit_x_s);
      axis_step(pos_y_r, v_y_s, LO_Y, HI_Y, SPAN_Y, step_py_s, step_vy_s, hit_y_s);

      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (step_s && (hit_x_s || hit_y_s) && (WRAP_MODE == 0) && (HOLD_FRAMES > 0)) begin
               state_s = ST_HOLD;
               hold_s  = HOLD_C;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_HOLD: begin
            if (bus.startOfFrame && (hold_r <= HC_W'(1'b1))) begin
               state_s = ST_RUN;
               hold_s  = {HC_W{1'b0}};
            end else if (bus.startOfFrame) begin
               hold_s  = hold_r - HC_W'(1'b1);
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: begin
            state_s = ST_IDLE;
            hold_s  = {HC_W{1'b0}};
         end
      endcase

      if (step_s) begin
         pos_x_s   = step_px_s;
         pos_y_s   = step_py_s;
         v_x_s     = step_vx_s;
         v_y_s     = step_vy_s;
         bounced_s = (hit_x_s | hit_y_s) & (WRAP_MODE == 0);
      end else begin
         bounced_s = 1'b0;
      end

      if (bus.stop) begin
         state_s = ST_IDLE;
         hold_s  = {HC_W{1'b0}};
      end else begin
         hold_s  = hold_s;
      end

      if (bus.load) begin
         pos_x_s  = {{2{bus.loadX[COORD_W-1]}}, bus.loadX, {FRAC_BITS{1'b0}}};
         pos_y_s  = {{2{bus.loadY[COORD_W-1]}}, bus.loadY, {FRAC_BITS{1'b0}}};
         v_x_s    = bus.loadVX;
         v_y_s    = bus.loadVY;
         lock_x_s = 1'b0;
         lock_y_s = 1'b0;
      end else begin
         lock_x_s = lock_x_s;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_r   <= ST_IDLE;
         hold_r    <= {HC_W{1'b0}};
         pos_x_r   <= INIT_PX;
         pos_y_r   <= INIT_PY;
         v_x_r     <= INIT_VX_C;
         v_y_r     <= INIT_VY_C;
         lock_x_r  <= 1'b0;
         lock_y_r  <= 1'b0;
         bounced_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         hold_r    <= hold_s;
         pos_x_r   <= pos_x_s;
         pos_y_r   <= pos_y_s;
         v_x_r     <= v_x_s;
         v_y_r     <= v_y_s;
         lock_x_r  <= lock_x_s;
         lock_y_r  <= lock_y_s;
         bounced_r <= bounced_s;
      end
   end

   assign bus.topLeftX = pos_x_r[FRAC_BITS +: COORD_W];
   assign bus.topLeftY = pos_y_r[FRAC_BITS +: COORD_W];
   assign bus.moving   = (state_r == ST_RUN);
   assign bus.bounced  = bounced_r;
endmodule

// File: tb/tb_rope_mover2d.sv
// Directed plus randomized bench for rope_mover2d: a bounce/hold instance tracked cycle by cycle
// against a frame-level reference model, and a wrap-mode instance checked against fixed values.
module tb_rope_mover2d;
   localparam int F = 64;

   logic clk = 1'b0;
   logic resetN;
   int   n_vec = 0;
   int   n_err = 0;

   // reference model: positions in 1/64 px, velocities in the same units
   int m_px, m_py, m_vx, m_vy, m_state, m_hold;
   bit m_lx, m_ly, m_bnc;
   localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2;

   rope_mover2d_if #(.COORD_W(11), .SPEED_W(16)) mb ();
   rope_mover2d_if #(.COORD_W(11), .SPEED_W(16)) wb ();

   rope_mover2d #(.HOLD_FRAMES(2)) dut_m (.clk(clk), .resetN(resetN), .bus(mb.slave));
   rope_mover2d #(.WRAP_MODE(1))   dut_w (.clk(clk), .resetN(resetN), .bus(wb.slave));

   always #5 clk = ~clk;

   function automatic int negsat(input int v);
      return (v == -32768) ? 32767 : -v;
   endfunction

   function automatic void step_axis(inout int p, inout int v, input int lo, input int hi, output bit hit);
      int n;
      n   = p + v;
      hit = 1'b0;
      if (n < lo * F) begin
         p = lo * F; v = (v < 0) ? negsat(v) : v; hit = 1'b1;
      end else if (n > hi * F) begin
         p = hi * F; v = (v > 0) ? negsat(v) : v; hit = 1'b1;
      end else begin
         p = n;
      end
   endfunction

   task automatic m_reset();
      m_px = 280 * F; m_py = 100 * F; m_vx = 30; m_vy = 0;
      m_state = M_IDLE; m_hold = 0; m_lx = 1'b0; m_ly = 1'b0; m_bnc = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic m_step();
      int os;
      bit hx, hy;
      os    = m_state;
      m_bnc = 1'b0;
      if (mb.dirToggleX && !m_lx) begin m_vx = negsat(m_vx); m_lx = 1'b1; end
      if (mb.dirToggleY && !m_ly) begin m_vy = negsat(m_vy); m_ly = 1'b1; end
      if (mb.startOfFrame) begin m_lx = 1'b0; m_ly = 1'b0; end
      if (os == M_HOLD && mb.startOfFrame) begin
         m_hold--;
         if (m_hold == 0) m_state = M_RUN;
      end
      if (os == M_IDLE && mb.start) m_state = M_RUN;
      if (mb.startOfFrame && os == M_RUN && !mb.load && !mb.stop) begin
         step_axis(m_px, m_vx, 0, 639, hx);
         step_axis(m_py, m_vy, 0, 479, hy);
         if (hx || hy) begin m_bnc = 1'b1; m_state = M_HOLD; m_hold = 2; end
      end
      if (mb.stop) begin m_state = M_IDLE; m_hold = 0; end
      if (mb.load) begin
         m_px = int'(mb.loadX) * F; m_py = int'(mb.loadY) * F;
         m_vx = int'(mb.loadVX);    m_vy = int'(mb.loadVY);
         m_lx = 1'b0; m_ly = 1'b0;
      end
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cmp_all();
      chk("topLeftX", mb.topLeftX, m_px >>> 6);
      chk("topLeftY", mb.topLeftY, m_py >>> 6);
      chk("moving",   mb.moving,   (m_state == M_RUN) ? 1 : 0);
      chk("bounced",  mb.bounced,  m_bnc ? 1 : 0);
   endtask

   task automatic cycle();
      m_step();
      @(posedge clk);
      #1;
      cmp_all();
   endtask

   task automatic frame(input int gap);
      mb.startOfFrame = 1'b1;
      cycle();
      mb.startOfFrame = 1'b0;
      repeat (gap) cycle();
   endtask

   task automatic do_load(input int x, input int y, input int vx, input int vy);
      mb.load = 1'b1; mb.loadX = 11'(x); mb.loadY = 11'(y); mb.loadVX = 16'(vx); mb.loadVY = 16'(vy);
   endtask

   initial begin
      resetN = 1'b0;
      {mb.startOfFrame, mb.start, mb.stop, mb.load, mb.dirToggleX, mb.dirToggleY} = 6'b000000;
      {wb.startOfFrame, wb.start, wb.stop, wb.load, wb.dirToggleX, wb.dirToggleY} = 6'b000000;
      mb.loadX = 11'sd0; mb.loadY = 11'sd0; mb.loadVX = 16'sd0; mb.loadVY = 16'sd0;
      wb.loadX = 11'sd0; wb.loadY = 11'sd0; wb.loadVX = 16'sd0; wb.loadVY = 16'sd0;
      m_reset();
      #12;
      chk("reset_x", mb.topLeftX, 280);
      chk("reset_y", mb.topLeftY, 100);
      chk("reset_moving", mb.moving, 0);
      chk("reset_bounced", mb.bounced, 0);
      @(posedge clk); #1;
      resetN = 1'b1;

      mb.start = 1'b1; cycle(); mb.start = 1'b0;
      chk("start_moving", mb.moving, 1);
      for (int i = 0; i < 64; i++) frame(1);
      chk("run64_x", mb.topLeftX, 310);
      chk("run64_y", mb.topLeftY, 100);

      // toggle held for several cycles negates only once
      mb.dirToggleX = 1'b1; repeat (5) cycle(); mb.dirToggleX = 1'b0;
      frame(1);
      chk("toggle_once_x", mb.topLeftX, 309);
      mb.dirToggleX = 1'b1; cycle(); mb.dirToggleX = 1'b0;
      frame(1);
      chk("toggle_rearm_x", mb.topLeftX, 310);

      do_load(638, 100, 128, 0); mb.stop = 1'b1; cycle(); mb.load = 1'b0; mb.stop = 1'b0;
      chk("loadstop_moving", mb.moving, 0);
      chk("loadstop_x", mb.topLeftX, 638);
      frame(1); frame(1);
      chk("idle_frozen_x", mb.topLeftX, 638);
      mb.start = 1'b1; mb.stop = 1'b1; cycle(); mb.start = 1'b0; mb.stop = 1'b0;
      chk("startstop_idle", mb.moving, 0);

      mb.start = 1'b1; cycle(); mb.start = 1'b0;
      mb.startOfFrame = 1'b1; cycle(); mb.startOfFrame = 1'b0;
      chk("bounce_x", mb.topLeftX, 639);
      chk("bounce_pulse", mb.bounced, 1);
      chk("bounce_hold", mb.moving, 0);
      cycle();
      chk("bounce_pulse_end", mb.bounced, 0);
      frame(1);
      chk("hold1_x", mb.topLeftX, 639);
      frame(1);
      chk("hold2_x", mb.topLeftX, 639);
      chk("hold_done_moving", mb.moving, 1);
      frame(1);
      chk("after_hold_x", mb.topLeftX, 637);

      // asynchronous reset in the middle of a hold
      do_load(638, 100, 128, 0); cycle(); mb.load = 1'b0;
      frame(1);
      #2; resetN = 1'b0; #1;
      m_reset();
      chk("async_rst_x", mb.topLeftX, 280);
      chk("async_rst_moving", mb.moving, 0);
      cmp_all();
      @(posedge clk); #1; resetN = 1'b1;
      mb.start = 1'b1; cycle(); mb.start = 1'b0;
      frame(1); frame(1);
      chk("post_rst_x", mb.topLeftX, 280);

      // saturating negation of the most negative velocity
      do_load(300, 100, -32768, 0); cycle(); mb.load = 1'b0;
      mb.dirToggleX = 1'b1; cycle(); mb.dirToggleX = 1'b0;
      frame(1);
      chk("sat_bounce_x", mb.topLeftX, 639);
      frame(1); frame(1);

      for (int i = 0; i < 500; i++) begin
         mb.startOfFrame = ($urandom_range(3, 0) == 0);
         mb.start        = ($urandom_range(7, 0) == 0);
         mb.stop         = ($urandom_range(49, 0) == 0);
         mb.dirToggleX   = ($urandom_range(5, 0) == 0);
         mb.dirToggleY   = ($urandom_range(5, 0) == 0);
         if ($urandom_range(24, 0) == 0) begin
            do_load($urandom_range(639, 0), $urandom_range(479, 0),
                    int'($urandom_range(6000, 0)) - 3000, int'($urandom_range(6000, 0)) - 3000);
         end else begin
            mb.load = 1'b0;
         end
         cycle();
      end
      {mb.startOfFrame, mb.start, mb.stop, mb.load, mb.dirToggleX, mb.dirToggleY} = 6'b000000;

      // wrap-mode instance
      wb.load = 1'b1; wb.loadX = 11'sd0; wb.loadY = 11'sd100; wb.loadVX = -16'sd64; wb.loadVY = 16'sd0;
      wb.start = 1'b1; cycle(); wb.load = 1'b0; wb.start = 1'b0;
      chk("wrap_moving", wb.moving, 1);
      wb.startOfFrame = 1'b1; cycle(); wb.startOfFrame = 1'b0;
      chk("wrap_x", wb.topLeftX, 639);
      chk("wrap_bounced", wb.bounced, 0);
      chk("wrap_y", wb.topLeftY, 100);
      cycle();
      wb.startOfFrame = 1'b1; cycle(); wb.startOfFrame = 1'b0;
      chk("wrap_next_x", wb.topLeftX, 638);
      chk("wrap_still_moving", wb.moving, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
